// File: rtl/reg_wr_pkg.sv
// Shared constants and decode helpers for the register write scoreboard.
// Pure package: no latency, no flow control.
package reg_wr_pkg;

  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned CNT_W_DEF  = 2;

  // Largest value an outstanding-write counter of the given width may hold.
  function automatic int unsigned cnt_max(input int unsigned cnt_w);
    return (32'd1 << cnt_w) - 32'd1;
  endfunction

  function automatic bit is_tracked(input int unsigned addr, input bit zero_ro);
    return !(zero_ro && (addr == 0));
  endfunction

  // One bit of the one-hot decode; a hardwired register 0 never decodes.
  function automatic bit onehot_bit(input int unsigned idx, input int unsigned addr,
                                    input bit zero_ro);
    return (idx == addr) && is_tracked(addr, zero_ro);
  endfunction

endpackage

// File: rtl/reg_busy_counter.sv
// Per-register outstanding-write counter; state updates on the edge after inc/dec.
// at_max lets the top stall issue instead of wrapping; underflow is sticky until reset.
module reg_busy_counter
  import reg_wr_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output logic busy,
  output logic at_max,
  output logic underflow
);

  localparam logic [CNT_W-1:0] MAX = CNT_W'(cnt_max(CNT_W));

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             underflow_q, underflow_d;

  always_comb begin
    cnt_d       = cnt_q;
    underflow_d = underflow_q;
    if (inc && !dec) begin
      if (cnt_q != MAX) cnt_d = cnt_q + 1'b1;
    end else if (dec && !inc) begin
      // A writeback with nothing outstanding is flagged, never wrapped.
      if (cnt_q == '0) underflow_d = 1'b1;
      else             cnt_d       = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      underflow_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      underflow_q <= underflow_d;
    end
  end

  assign busy      = (cnt_q != '0);
  assign at_max    = (cnt_q == MAX);
  assign underflow = underflow_q;

endmodule

// File: rtl/reg_write_scoreboard.sv
// Writeback decode to a registered one-hot wr_en (1 cycle) plus per-register scoreboard.
// iss_ready drops only when the destination counter is full and no same-cycle writeback frees it.
module reg_write_scoreboard
  import reg_wr_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter bit          ZERO_REG_RO = 1'b1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       wb_valid,
  input  logic [ADDR_W-1:0]          wb_addr,
  output logic [(1<<ADDR_W)-1:0]     wr_en,
  input  logic                       iss_valid,
  input  logic                       iss_has_dst,
  input  logic [ADDR_W-1:0]          iss_dst,
  output logic                       iss_ready,
  input  logic [ADDR_W-1:0]          src_a,
  input  logic [ADDR_W-1:0]          src_b,
  output logic                       src_hazard,
  output logic [(1<<ADDR_W)-1:0]     busy,
  output logic                       err_underflow
);

  localparam int unsigned NUM_REGS = 1 << ADDR_W;

  function automatic logic [NUM_REGS-1:0] onehot(input logic [ADDR_W-1:0] addr);
    logic [NUM_REGS-1:0] v;
    for (int unsigned i = 0; i < NUM_REGS; i++) v[i] = onehot_bit(i, 32'(addr), ZERO_REG_RO);
    return v;
  endfunction

  logic [NUM_REGS-1:0] wr_en_q, wr_en_d;
  logic [NUM_REGS-1:0] inc_vec;
  logic [NUM_REGS-1:0] at_max_vec;
  logic [NUM_REGS-1:0] underflow_vec;

  always_comb begin
    wr_en_d   = wb_valid ? onehot(wb_addr) : '0;
    // A same-cycle writeback to the destination makes room even at MAX.
    iss_ready = !iss_has_dst
              || !is_tracked(32'(iss_dst), ZERO_REG_RO)
              || !at_max_vec[iss_dst]
              || (wb_valid && (wb_addr == iss_dst));
    inc_vec   = (iss_valid && iss_ready && iss_has_dst) ? onehot(iss_dst) : '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) wr_en_q <= '0;
    else       wr_en_q <= wr_en_d;
  end

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_cnt
    reg_busy_counter #(.CNT_W(CNT_W)) u_cnt (
      .clock     (clock),
      .reset     (reset),
      .inc       (inc_vec[r]),
      .dec       (wr_en_d[r]),
      .busy      (busy[r]),
      .at_max    (at_max_vec[r]),
      .underflow (underflow_vec[r])
    );
  end

  // No bypass: hazard reflects registered counters only.
  assign src_hazard    = busy[src_a] | busy[src_b];
  assign err_underflow = |underflow_vec;
  assign wr_en         = wr_en_q;

endmodule

// File: tb/tb_reg_write_scoreboard.sv
// Directed bench for reg_write_scoreboard with hand-computed expectations.
module tb_reg_write_scoreboard;

  logic        clock = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wr_en;
  logic        iss_valid;
  logic        iss_has_dst;
  logic [4:0]  iss_dst;
  logic        iss_ready;
  logic [4:0]  src_a;
  logic [4:0]  src_b;
  logic        src_hazard;
  logic [31:0] busy;
  logic        err_underflow;

  int checks = 0;
  int errors = 0;

  reg_write_scoreboard dut (
    .clock         (clock),
    .reset         (reset),
    .wb_valid      (wb_valid),
    .wb_addr       (wb_addr),
    .wr_en         (wr_en),
    .iss_valid     (iss_valid),
    .iss_has_dst   (iss_has_dst),
    .iss_dst       (iss_dst),
    .iss_ready     (iss_ready),
    .src_a         (src_a),
    .src_b         (src_b),
    .src_hazard    (src_hazard),
    .busy          (busy),
    .err_underflow (err_underflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reset asserted and released between edges.
  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1; wb_valid = 0; wb_addr = 0; iss_valid = 0; iss_has_dst = 0;
    iss_dst = 0; src_a = 0; src_b = 0;
    #12;
    check("rst_wr_en", wr_en, 32'h0);
    check("rst_busy", busy, 32'h0);
    check("rst_hazard", {31'b0, src_hazard}, 32'h0);
    check("rst_err", {31'b0, err_underflow}, 32'h0);
    @(negedge clock);
    reset = 1'b0;

    // 1: one-hot write-enable decode
    wb_valid = 1; wb_addr = 5'd5;
    tick();
    wb_valid = 0;
    check("wr_en_5", wr_en, 32'h0000_0020);
    tick();
    check("wr_en_idle", wr_en, 32'h0);
    wb_valid = 1; wb_addr = 5'd0;
    tick();
    check("wr_en_r0", wr_en, 32'h0);
    wb_addr = 5'd31;
    tick();
    wb_valid = 0;
    check("wr_en_31", wr_en, 32'h8000_0000);
    check("err_after_t1", {31'b0, err_underflow}, 32'h1);

    // 2: single pending write and hazard
    pulse_reset();
    iss_valid = 1; iss_has_dst = 1; iss_dst = 5'd3;
    #1;
    check("t2_ready", {31'b0, iss_ready}, 32'h1);
    tick();
    iss_valid = 0;
    check("t2_busy3", busy, 32'h0000_0008);
    src_a = 5'd3;
    #1;
    check("t2_hazard", {31'b0, src_hazard}, 32'h1);
    wb_valid = 1; wb_addr = 5'd3;
    #1;
    check("t2_no_bypass", {31'b0, src_hazard}, 32'h1);
    tick();
    wb_valid = 0;
    check("t2_busy_clr", busy, 32'h0);
    check("t2_hazard_clr", {31'b0, src_hazard}, 32'h0);
    check("t2_wr_en3", wr_en, 32'h0000_0008);
    check("t2_err", {31'b0, err_underflow}, 32'h0);
    src_a = 5'd0;

    // 3: saturation at MAX=3
    pulse_reset();
    iss_valid = 1; iss_has_dst = 1; iss_dst = 5'd7;
    tick(); tick(); tick();
    check("t3_full_ready7", {31'b0, iss_ready}, 32'h0);
    iss_valid = 0;
    iss_dst = 5'd8;
    #1;
    check("t3_ready8", {31'b0, iss_ready}, 32'h1);
    iss_dst = 5'd7; iss_valid = 1; wb_valid = 1; wb_addr = 5'd7;
    #1;
    check("t3_ready_wb", {31'b0, iss_ready}, 32'h1);
    tick();
    iss_valid = 0; wb_valid = 0;
    #1;
    check("t3_still_full", {31'b0, iss_ready}, 32'h0);
    check("t3_wr_en7", wr_en, 32'h0000_0080);
    wb_valid = 1; wb_addr = 5'd7;
    tick(); tick();
    check("t3_busy_cnt1", busy, 32'h0000_0080);
    tick();
    wb_valid = 0;
    check("t3_busy_cnt0", busy, 32'h0);
    check("t3_err", {31'b0, err_underflow}, 32'h0);

    // 4: underflow is sticky
    pulse_reset();
    iss_has_dst = 0;
    wb_valid = 1; wb_addr = 5'd9;
    tick();
    wb_valid = 0;
    check("t4_wr_en9", wr_en, 32'h0000_0200);
    check("t4_err", {31'b0, err_underflow}, 32'h1);
    check("t4_busy", busy, 32'h0);
    tick(); tick();
    check("t4_wr_en_off", wr_en, 32'h0);
    check("t4_err_sticky", {31'b0, err_underflow}, 32'h1);
    pulse_reset();
    check("t4_err_cleared", {31'b0, err_underflow}, 32'h0);

    // 5: register 0 untracked
    iss_valid = 1; iss_has_dst = 1; iss_dst = 5'd0;
    #1;
    check("t5_ready0", {31'b0, iss_ready}, 32'h1);
    tick();
    iss_valid = 0;
    src_a = 5'd0; src_b = 5'd0;
    #1;
    check("t5_busy0", busy, 32'h0);
    check("t5_hazard0", {31'b0, src_hazard}, 32'h0);

    // 6: asynchronous reset mid-operation
    iss_valid = 1; iss_dst = 5'd2;
    tick();
    iss_dst = 5'd4;
    tick();
    iss_valid = 0;
    check("t6_busy_2_4", busy, 32'h0000_0014);
    src_a = 5'd2; src_b = 5'd4;
    #1;
    check("t6_hazard", {31'b0, src_hazard}, 32'h1);
    wb_valid = 1; wb_addr = 5'd6;
    tick();
    wb_valid = 0;
    check("t6_wr_en6", wr_en, 32'h0000_0040);
    check("t6_err_set", {31'b0, err_underflow}, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_busy", busy, 32'h0);
    check("t6_async_wr_en", wr_en, 32'h0);
    check("t6_async_err", {31'b0, err_underflow}, 32'h0);
    check("t6_async_hazard", {31'b0, src_hazard}, 32'h0);
    reset = 1'b0;
    iss_valid = 1; iss_dst = 5'd4;
    tick();
    iss_valid = 0;
    check("t6_fresh_busy", busy, 32'h0000_0010);
    check("t6_fresh_hazard", {31'b0, src_hazard}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
